// File: rtl/acc_dispatcher_if.sv
// Channel bundle between the issue stage, the accelerator and the register
// file writeback port. The dispatcher takes the slave view; the surrounding
// environment (issue stage, accelerator, register file) takes the master view.
interface acc_dispatcher_if #(
    parameter int ACC_DATA_WIDTH     = 64,
    parameter int ACC_INSTR_WIDTH    = 32,
    parameter int ACC_REG_ADDR_WIDTH = 5
);
    // issue stage -> dispatcher
    logic                          issue_valid_i;
    logic                          issue_ready_o;
    logic [ACC_INSTR_WIDTH-1:0]    issue_instr_i;
    logic [ACC_DATA_WIDTH-1:0]     issue_rs1_i;
    logic [ACC_DATA_WIDTH-1:0]     issue_rs2_i;
    // dispatcher -> accelerator command
    logic                          cmd_valid_o;
    logic                          cmd_ready_i;
    logic [ACC_INSTR_WIDTH-1:0]    cmd_instr_o;
    logic [ACC_DATA_WIDTH-1:0]     cmd_rs1_o;
    logic [ACC_DATA_WIDTH-1:0]     cmd_rs2_o;
    // accelerator -> dispatcher response
    logic                          resp_valid_i;
    logic                          resp_ready_o;
    logic [ACC_DATA_WIDTH-1:0]     resp_data_i;
    logic [ACC_REG_ADDR_WIDTH-1:0] resp_rd_i;
    // dispatcher -> register file writeback
    logic                          wb_valid_o;
    logic                          wb_ready_i;
    logic [ACC_DATA_WIDTH-1:0]     wb_data_o;
    logic [ACC_REG_ADDR_WIDTH-1:0] wb_rd_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i,
        output issue_ready_o,
        output cmd_valid_o, cmd_instr_o, cmd_rs1_o, cmd_rs2_o,
        input  cmd_ready_i,
        input  resp_valid_i, resp_data_i, resp_rd_i,
        output resp_ready_o,
        output wb_valid_o, wb_data_o, wb_rd_o,
        input  wb_ready_i
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i,
        input  issue_ready_o,
        input  cmd_valid_o, cmd_instr_o, cmd_rs1_o, cmd_rs2_o,
        output cmd_ready_i,
        output resp_valid_i, resp_data_i, resp_rd_i,
        input  resp_ready_o,
        input  wb_valid_o, wb_data_o, wb_rd_o,
        output wb_ready_i
    );
endinterface

// File: rtl/acc_dispatcher.sv
// Accelerator dispatcher: command FIFO towards the accelerator, capped
// in-flight counter, and a single-entry writeback register for responses.
module acc_dispatcher #(
    parameter int ACC_DATA_WIDTH     = 64,
    parameter int ACC_INSTR_WIDTH    = 32,
    parameter int ACC_REG_ADDR_WIDTH = 5,
    parameter int CMD_DEPTH          = 4,
    parameter int MAX_OUTSTANDING    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    acc_dispatcher_if.slave    bus,
    output logic [7:0]         outstanding_o,
    output logic               busy_o,
    output logic               err_o
);
    localparam int         AW      = $clog2(CMD_DEPTH);
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef struct packed {
        logic [ACC_INSTR_WIDTH-1:0] instr;
        logic [ACC_DATA_WIDTH-1:0]  rs1;
        logic [ACC_DATA_WIDTH-1:0]  rs2;
    } cmd_t;

    cmd_t                          mem_q [CMD_DEPTH];
    logic [AW:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic                          wb_valid_q, wb_valid_d;
    logic [ACC_DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [ACC_REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                          err_q, err_d;

    logic empty, full, push, pop, resp_fire, resp_take, wb_fire;
    cmd_t head;

    // Extra pointer MSB tells a full FIFO from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Readies/valids are gated by reset so nothing handshakes in the reset cycle.
    assign bus.issue_ready_o = !rst_i && !full && !flush_i;
    assign bus.cmd_valid_o   = !rst_i && !empty && (cnt_q < MAX_OUT);
    assign bus.cmd_instr_o   = head.instr;
    assign bus.cmd_rs1_o     = head.rs1;
    assign bus.cmd_rs2_o     = head.rs2;
    assign bus.resp_ready_o  = !rst_i && (!wb_valid_q || bus.wb_ready_i);
    assign bus.wb_valid_o    = !rst_i && wb_valid_q;
    assign bus.wb_data_o     = wb_data_q;
    assign bus.wb_rd_o       = wb_rd_q;

    assign push      = bus.issue_valid_i && bus.issue_ready_o;
    assign pop       = bus.cmd_valid_o && bus.cmd_ready_i;
    assign resp_fire = bus.resp_valid_i && bus.resp_ready_o;
    // A response with nothing in flight is flagged and dropped.
    assign resp_take = resp_fire && (cnt_q != 8'd0);
    assign wb_fire   = bus.wb_valid_o && bus.wb_ready_i;

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;
    assign busy_o        = !empty || (cnt_q != 8'd0) || wb_valid_q;

    // Next-state for pointers, in-flight counter, writeback register and error flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        err_d      = err_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        // Flush drops queued entries; a pop in the same cycle still counts below.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        case ({pop, resp_take})
            2'b10:   cnt_d = cnt_q + 8'd1;
            2'b01:   cnt_d = cnt_q - 8'd1;
            default: cnt_d = cnt_q;
        endcase
        if (resp_take) begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus.resp_data_i;
            wb_rd_d    = bus.resp_rd_i;
        end else if (wb_fire) begin
            wb_valid_d = 1'b0;
        end
        if (resp_fire && (cnt_q == 8'd0)) err_d = 1'b1;
    end

    // Control and writeback state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.issue_instr_i, bus.issue_rs1_i, bus.issue_rs2_i};
    end
endmodule

// File: tb/tb_acc_dispatcher.sv
// Bench for acc_dispatcher: reset, FIFO fill/drain vector table, writeback
// back-pressure, unexpected response, flush, mid-transfer reset, and the
// in-flight cap on a second instance with MAX_OUTSTANDING = 2.
module tb_acc_dispatcher;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_a = 1'b0, flush_b = 1'b0;
    logic [7:0] out_a, out_b;
    logic       busy_a, busy_b, err_a, err_b;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    acc_dispatcher_if #(.ACC_DATA_WIDTH(64), .ACC_INSTR_WIDTH(32), .ACC_REG_ADDR_WIDTH(5)) a_if ();
    acc_dispatcher_if #(.ACC_DATA_WIDTH(64), .ACC_INSTR_WIDTH(32), .ACC_REG_ADDR_WIDTH(5)) b_if ();

    acc_dispatcher dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .bus(a_if),
        .outstanding_o(out_a), .busy_o(busy_a), .err_o(err_a)
    );
    acc_dispatcher #(.MAX_OUTSTANDING(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .bus(b_if),
        .outstanding_o(out_b), .busy_o(busy_b), .err_o(err_b)
    );

    typedef struct packed { logic [31:0] instr; logic [63:0] rs1; logic [63:0] rs2; } ecmd_t;
    typedef struct packed { logic [63:0] d; logic [4:0] rd; } ewb_t;
    typedef struct {
        logic iv; logic cr; logic [31:0] instr; logic [63:0] rs1; logic [63:0] rs2;
        logic e_ir; logic e_cv; logic [7:0] e_out;
    } vec_t;

    ecmd_t cmd_q[$];
    ewb_t  wb_q[$];
    int    m_out = 0;
    bit    m_err = 1'b0;
    vec_t  vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard for dut_a: called once per cycle at the falling edge.
    task automatic mon();
        ecmd_t ec;
        ewb_t  ew;
        bit    cf, rf, wf, rok;
        if (rst) begin
            cmd_q.delete(); wb_q.delete(); m_out = 0; m_err = 1'b0;
            return;
        end
        chk("mon_cmd_valid", a_if.cmd_valid_o, (cmd_q.size() != 0) && (m_out < 8));
        chk("mon_outstanding", out_a, m_out);
        chk("mon_err", err_a, m_err);
        chk("mon_wb_valid", a_if.wb_valid_o, wb_q.size() != 0);
        chk("mon_busy", busy_a, (cmd_q.size() != 0) || (m_out != 0) || (wb_q.size() != 0));
        cf  = a_if.cmd_valid_o && a_if.cmd_ready_i;
        rf  = a_if.resp_valid_i && a_if.resp_ready_o;
        wf  = a_if.wb_valid_o && a_if.wb_ready_i;
        rok = rf && (m_out != 0);
        if (wf) begin
            if (wb_q.size() == 0) begin
                total++; bad++; $display("FAIL wb_extra: got wb fire want none");
            end else begin
                ew = wb_q.pop_front();
                chk("wb_data", a_if.wb_data_o, ew.d);
                chk("wb_rd", a_if.wb_rd_o, ew.rd);
            end
        end
        if (rok) wb_q.push_back('{d: a_if.resp_data_i, rd: a_if.resp_rd_i});
        if (rf && m_out == 0) m_err = 1'b1;
        m_out = m_out + (cf ? 1 : 0) - (rok ? 1 : 0);
        if (cf) begin
            if (cmd_q.size() == 0) begin
                total++; bad++; $display("FAIL cmd_extra: got cmd fire want none");
            end else begin
                ec = cmd_q.pop_front();
                chk("cmd_instr", a_if.cmd_instr_o, ec.instr);
                chk("cmd_rs1", a_if.cmd_rs1_o, ec.rs1);
                chk("cmd_rs2", a_if.cmd_rs2_o, ec.rs2);
            end
        end
        if (flush_a) cmd_q.delete();
        if (a_if.issue_valid_i && a_if.issue_ready_o)
            cmd_q.push_back('{instr: a_if.issue_instr_i, rs1: a_if.issue_rs1_i, rs2: a_if.issue_rs2_i});
    endtask

    task automatic to_neg(); @(negedge clk); mon(); endtask
    task automatic to_pos(); @(posedge clk); #1; endtask
    task automatic cyc();    to_neg(); to_pos(); endtask

    task automatic setv(input int k, input logic iv, input logic cr, input logic [31:0] ins,
                        input logic [63:0] r1, input logic [63:0] r2,
                        input logic eir, input logic ecv, input logic [7:0] eo);
        vt[k].iv = iv; vt[k].cr = cr; vt[k].instr = ins; vt[k].rs1 = r1; vt[k].rs2 = r2;
        vt[k].e_ir = eir; vt[k].e_cv = ecv; vt[k].e_out = eo;
    endtask

    task automatic push_a(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
        a_if.issue_valid_i = 1'b1; a_if.issue_instr_i = ins;
        a_if.issue_rs1_i = r1; a_if.issue_rs2_i = r2;
    endtask

    task automatic resp_a(input logic v, input logic [63:0] d, input logic [4:0] rd);
        a_if.resp_valid_i = v; a_if.resp_data_i = d; a_if.resp_rd_i = rd;
    endtask

    initial begin
        a_if.issue_valid_i = 0; a_if.issue_instr_i = 0; a_if.issue_rs1_i = 0; a_if.issue_rs2_i = 0;
        a_if.cmd_ready_i = 0; a_if.resp_valid_i = 0; a_if.resp_data_i = 0; a_if.resp_rd_i = 0;
        a_if.wb_ready_i = 0;
        b_if.issue_valid_i = 0; b_if.issue_instr_i = 0; b_if.issue_rs1_i = 0; b_if.issue_rs2_i = 0;
        b_if.cmd_ready_i = 0; b_if.resp_valid_i = 0; b_if.resp_data_i = 0; b_if.resp_rd_i = 0;
        b_if.wb_ready_i = 0;

        // Fill/drain table: 4 pushes with the accelerator stalled, then drain.
        for (int i = 0; i < 4; i++)
            setv(i, 1, 0, 32'h0000_000B + i, 64'(i), 64'(10 * i), 1, (i != 0), 0);
        setv(4, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 5; i < 9; i++)
            setv(i, 0, 1, 0, 0, 0, (i != 5), 1, 8'(i - 5));
        setv(9, 0, 1, 0, 0, 0, 1, 0, 4);

        // Reset state.
        to_pos(); to_pos();
        to_neg();
        chk("rst_issue_ready", a_if.issue_ready_o, 0);
        chk("rst_resp_ready", a_if.resp_ready_o, 0);
        chk("rst_cmd_valid", a_if.cmd_valid_o, 0);
        chk("rst_wb_valid", a_if.wb_valid_o, 0);
        chk("rst_outstanding", out_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_busy", busy_a, 0);
        to_pos();
        rst = 1'b0;
        to_neg();
        chk("post_rst_issue_ready", a_if.issue_ready_o, 1);
        chk("post_rst_resp_ready", a_if.resp_ready_o, 1);
        to_pos();

        for (int k = 0; k < 10; k++) begin
            a_if.issue_valid_i = vt[k].iv; a_if.cmd_ready_i = vt[k].cr;
            a_if.issue_instr_i = vt[k].instr; a_if.issue_rs1_i = vt[k].rs1; a_if.issue_rs2_i = vt[k].rs2;
            to_neg();
            chk($sformatf("vec%0d_issue_ready", k), a_if.issue_ready_o, vt[k].e_ir);
            chk($sformatf("vec%0d_cmd_valid", k), a_if.cmd_valid_o, vt[k].e_cv);
            chk($sformatf("vec%0d_outstanding", k), out_a, vt[k].e_out);
            to_pos();
        end
        a_if.cmd_ready_i = 0;

        // Writeback back-pressure: first response held for 3 cycles.
        resp_a(1, 64'hDEAD_BEEF, 7);
        to_neg(); chk("resp0_ready", a_if.resp_ready_o, 1); to_pos();
        resp_a(1, 64'h1234_5678, 3);
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("hold_wb_valid", a_if.wb_valid_o, 1);
            chk("hold_wb_data", a_if.wb_data_o, 64'hDEAD_BEEF);
            chk("hold_wb_rd", a_if.wb_rd_o, 7);
            chk("hold_resp_ready", a_if.resp_ready_o, 0);
            to_pos();
        end
        a_if.wb_ready_i = 1;
        to_neg(); chk("resume_resp_ready", a_if.resp_ready_o, 1); to_pos();
        resp_a(0, 0, 0);
        to_neg(); chk("second_wb_data", a_if.wb_data_o, 64'h1234_5678); to_pos();
        to_neg(); chk("after_drain_out", out_a, 2); to_pos();

        // Back-to-back responses at full rate.
        for (int i = 0; i < 2; i++) begin
            resp_a(1, 64'hA0 + i, 5'(10 + i));
            to_neg(); chk("b2b_resp_ready", a_if.resp_ready_o, 1); to_pos();
        end
        resp_a(0, 0, 0);
        cyc();
        to_neg(); chk("b2b_out_zero", out_a, 0); to_pos();

        // Unexpected response.
        resp_a(1, 64'hBAD, 1);
        cyc();
        resp_a(0, 0, 0);
        to_neg();
        chk("unexp_err", err_a, 1);
        chk("unexp_wb_valid", a_if.wb_valid_o, 0);
        chk("unexp_out", out_a, 0);
        to_pos();

        // Flush with 3 queued and 1 outstanding.
        push_a(32'h100, 1, 2); cyc();
        a_if.issue_valid_i = 0; a_if.cmd_ready_i = 1; cyc();
        a_if.cmd_ready_i = 0;
        for (int i = 1; i < 4; i++) begin push_a(32'h100 + i, 64'(i), 64'(i)); cyc(); end
        push_a(32'h1FF, 0, 0); flush_a = 1;
        to_neg(); chk("flush_issue_ready", a_if.issue_ready_o, 0); to_pos();
        flush_a = 0; a_if.issue_valid_i = 0;
        to_neg();
        chk("flush_cmd_valid", a_if.cmd_valid_o, 0);
        chk("flush_issue_ready_back", a_if.issue_ready_o, 1);
        chk("flush_out", out_a, 1);
        chk("flush_busy", busy_a, 1);
        to_pos();
        resp_a(1, 64'h55, 2); cyc();
        resp_a(0, 0, 0); cyc();
        to_neg();
        chk("flush_final_busy", busy_a, 0);
        chk("flush_final_out", out_a, 0);
        chk("flush_err_sticky", err_a, 1);
        to_pos();

        // Reset mid-transfer: 2 queued, writeback pending.
        a_if.wb_ready_i = 0;
        push_a(32'h200, 0, 0); cyc();
        a_if.issue_valid_i = 0; a_if.cmd_ready_i = 1; cyc();
        a_if.cmd_ready_i = 0;
        push_a(32'h201, 1, 1); cyc();
        push_a(32'h202, 2, 2); cyc();
        a_if.issue_valid_i = 0;
        resp_a(1, 64'h77, 4); cyc();
        resp_a(0, 0, 0);
        to_neg(); chk("pre_rst_wb_valid", a_if.wb_valid_o, 1); to_pos();
        rst = 1; a_if.wb_ready_i = 1;
        to_neg();
        chk("in_rst_issue_ready", a_if.issue_ready_o, 0);
        chk("in_rst_resp_ready", a_if.resp_ready_o, 0);
        to_pos();
        rst = 0; a_if.wb_ready_i = 0;
        to_neg();
        chk("mid_rst_cmd_valid", a_if.cmd_valid_o, 0);
        chk("mid_rst_wb_valid", a_if.wb_valid_o, 0);
        chk("mid_rst_out", out_a, 0);
        chk("mid_rst_err", err_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_wb_data", a_if.wb_data_o, 0);
        chk("mid_rst_wb_rd", a_if.wb_rd_o, 0);
        chk("mid_rst_issue_ready", a_if.issue_ready_o, 1);
        chk("mid_rst_resp_ready", a_if.resp_ready_o, 1);
        to_pos();

        // In-flight cap on dut_b (MAX_OUTSTANDING = 2).
        for (int i = 0; i < 3; i++) begin
            b_if.issue_valid_i = 1; b_if.issue_instr_i = 32'h300 + i;
            b_if.issue_rs1_i = 64'(i); b_if.issue_rs2_i = 64'(i);
            cyc();
        end
        b_if.issue_valid_i = 0; b_if.cmd_ready_i = 1; b_if.wb_ready_i = 1;
        to_neg();
        chk("cap_c0_cmd_valid", b_if.cmd_valid_o, 1);
        chk("cap_c0_instr", b_if.cmd_instr_o, 32'h300);
        chk("cap_c0_out", out_b, 0);
        to_pos();
        to_neg();
        chk("cap_c1_cmd_valid", b_if.cmd_valid_o, 1);
        chk("cap_c1_instr", b_if.cmd_instr_o, 32'h301);
        chk("cap_c1_out", out_b, 1);
        to_pos();
        to_neg();
        chk("cap_c2_cmd_valid", b_if.cmd_valid_o, 0);
        chk("cap_c2_out", out_b, 2);
        chk("cap_c2_busy", busy_b, 1);
        to_pos();
        b_if.resp_valid_i = 1; b_if.resp_data_i = 64'h9; b_if.resp_rd_i = 5'd9;
        to_neg();
        chk("cap_c3_cmd_valid", b_if.cmd_valid_o, 0);
        chk("cap_c3_resp_ready", b_if.resp_ready_o, 1);
        to_pos();
        b_if.resp_valid_i = 0;
        to_neg();
        chk("cap_c4_cmd_valid", b_if.cmd_valid_o, 1);
        chk("cap_c4_instr", b_if.cmd_instr_o, 32'h302);
        chk("cap_c4_out", out_b, 1);
        to_pos();
        to_neg();
        chk("cap_c5_cmd_valid", b_if.cmd_valid_o, 0);
        chk("cap_c5_out", out_b, 2);
        to_pos();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
